// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: widths, result-source and load-funct3
// encodings, and the write-back FSM state type.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_IMM = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef logic [1:0] wb_state_t;
    localparam wb_state_t ST_INIT  = 2'd0;
    localparam wb_state_t ST_CLEAR = 2'd1;
    localparam wb_state_t ST_RUN   = 2'd2;

endpackage

// File: rtl/load_extend.sv
// Combinational load data extraction: picks the byte/halfword lane addressed
// by the low address bits and sign- or zero-extends it to XLEN.
module load_extend #(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic [XLEN-1:0] inMemData,
    input  logic [1:0]      inAddrLow,
    input  logic [2:0]      inLoadFunct3,
    output logic [XLEN-1:0] result
);
    import riscv_pkg::*;

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        case (inAddrLow)
            2'd0:    lane_byte = inMemData[7:0];
            2'd1:    lane_byte = inMemData[15:8];
            2'd2:    lane_byte = inMemData[23:16];
            default: lane_byte = inMemData[31:24];
        endcase
        // Halfword lane follows bit 1 only; misaligned bit 0 is ignored.
        lane_half = inAddrLow[1] ? inMemData[31:16] : inMemData[15:0];
    end

    always_comb begin
        case (inLoadFunct3)
            F3_LB:   result = {{(XLEN-8){lane_byte[7]}}, lane_byte};
            F3_LH:   result = {{(XLEN-16){lane_half[15]}}, lane_half};
            F3_LW:   result = inMemData;
            F3_LBU:  result = {{(XLEN-8){1'b0}}, lane_byte};
            F3_LHU:  result = {{(XLEN-16){1'b0}}, lane_half};
            default: result = inMemData;
        endcase
    end

endmodule

// File: rtl/register_writeback.sv
// Write-back stage: zero-clears x1..x31 after reset, then registers one
// retiring result per cycle and drives the register-file write port.
module register_writeback #(
    parameter int XLEN           = riscv_pkg::XLEN,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            inValid,
    output logic            inReady,
    input  logic            inRegWrite,
    input  logic [4:0]      inRd,
    input  logic [1:0]      inResultSrc,
    input  logic [XLEN-1:0] inAluResult,
    input  logic [XLEN-1:0] inPcPlus4,
    input  logic [XLEN-1:0] inImm,
    input  logic [XLEN-1:0] inMemData,
    input  logic [2:0]      inLoadFunct3,
    input  logic [1:0]      inAddrLow,
    output logic            regWrite,
    output logic [4:0]      writeRegister,
    output logic [XLEN-1:0] writeData,
    output logic            clearDone
);
    import riscv_pkg::*;

    wb_state_t             state;
    logic [REG_ADDR_W-1:0] clearCnt;
    logic                  wbValid;
    logic [REG_ADDR_W-1:0] wbRd;
    logic [XLEN-1:0]       wbData;
    logic [XLEN-1:0]       loadData;
    logic [XLEN-1:0]       selData;
    logic                  accept;

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .inMemData    (inMemData),
        .inAddrLow    (inAddrLow),
        .inLoadFunct3 (inLoadFunct3),
        .result       (loadData)
    );

    always_comb begin
        case (inResultSrc)
            RES_MEM: selData = loadData;
            RES_PC4: selData = inPcPlus4;
            RES_IMM: selData = inImm;
            default: selData = inAluResult;
        endcase
    end

    // Outputs are masked while reset is high so a pending write is dropped
    // in the very cycle reset is asserted, not one cycle later.
    assign inReady   = (state == ST_RUN) && !reset;
    assign clearDone = (state == ST_RUN) && !reset;
    assign accept    = inValid && inReady;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_INIT;
            clearCnt <= REG_ADDR_W'(1);
            wbValid  <= 1'b0;
            wbRd     <= '0;
            wbData   <= '0;
        end else begin
            case (state)
                ST_INIT: state <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
                ST_CLEAR: begin
                    if (clearCnt == '1) state <= ST_RUN;
                    else                clearCnt <= clearCnt + 1'b1;
                end
                ST_RUN: begin
                    wbValid <= accept && inRegWrite && (inRd != '0);
                    if (accept) begin
                        wbRd   <= inRd;
                        wbData <= selData;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    always_comb begin
        regWrite      = 1'b0;
        writeRegister = '0;
        writeData     = '0;
        if (!reset) begin
            case (state)
                ST_CLEAR: begin
                    regWrite      = 1'b1;
                    writeRegister = clearCnt;
                end
                ST_RUN: begin
                    regWrite      = wbValid;
                    writeRegister = wbRd;
                    writeData     = wbData;
                end
                default: ;
            endcase
        end
    end

endmodule
